// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor slice plus a borrow flip-flop
// computes a - b LSB first, with a start/busy/done handshake.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // One full-subtractor slice; returns {borrow_out, diff}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
        full_sub = {(~x & y) | (~(x ^ y) & bin), x ^ y ^ bin};
    endfunction

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] a_sr_r, a_sr_nxt_s;
    logic [WIDTH-1:0] b_sr_r, b_sr_nxt_s;
    logic [WIDTH-1:0] r_sr_r, r_sr_nxt_s;
    logic             br_r, br_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] d_r, d_nxt_s;
    logic             bout_r, bout_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;

    logic [1:0]       slice_s;
    logic [WIDTH-1:0] r_shift_s;

    // Current bit of the subtraction and the result register shifted to take it.
    always_comb begin
        slice_s              = full_sub(a_sr_r[0], b_sr_r[0], br_r);
        r_shift_s            = r_sr_r >> 1'b1;
        r_shift_s[WIDTH-1]   = slice_s[0];
    end

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_nxt_s = state_r;
        a_sr_nxt_s  = a_sr_r;
        b_sr_nxt_s  = b_sr_r;
        r_sr_nxt_s  = r_sr_r;
        br_nxt_s    = br_r;
        cnt_nxt_s   = cnt_r;
        d_nxt_s     = d_r;
        bout_nxt_s  = bout_r;
        busy_nxt_s  = busy_r;
        done_nxt_s  = 1'b0;

        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt_s = RUN;
                    a_sr_nxt_s  = a;
                    b_sr_nxt_s  = b;
                    r_sr_nxt_s  = {WIDTH{1'b0}};
                    br_nxt_s    = 1'b0;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    busy_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end
            end
            RUN: begin
                // start is deliberately ignored here; operands were latched at acceptance
                a_sr_nxt_s = a_sr_r >> 1'b1;
                b_sr_nxt_s = b_sr_r >> 1'b1;
                r_sr_nxt_s = r_shift_s;
                br_nxt_s   = slice_s[1];
                cnt_nxt_s  = cnt_r + CNT_ONE;
                if (cnt_r == LAST_CNT) begin
                    state_nxt_s = DONE;
                    d_nxt_s     = r_shift_s;
                    bout_nxt_s  = slice_s[1];
                    done_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset wins over everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            a_sr_r  <= {WIDTH{1'b0}};
            b_sr_r  <= {WIDTH{1'b0}};
            r_sr_r  <= {WIDTH{1'b0}};
            br_r    <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            d_r     <= {WIDTH{1'b0}};
            bout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_sr_r  <= a_sr_nxt_s;
            b_sr_r  <= b_sr_nxt_s;
            r_sr_r  <= r_sr_nxt_s;
            br_r    <= br_nxt_s;
            cnt_r   <= cnt_nxt_s;
            d_r     <= d_nxt_s;
            bout_r  <= bout_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign d    = d_r;
    assign bout = bout_r;

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (WIDTH=8 and WIDTH=1 instances) against
// a plain-arithmetic model of a - b.
module tb_serial_sub;

    logic       clk;
    logic       rst8, start8, busy8, done8, bout8;
    logic [7:0] a8, b8, d8;
    logic       rst1, start1, busy1, done1, bout1;
    logic [0:0] a1, b1, d1;

    int total = 0;
    int bad   = 0;

    logic [7:0] last_d;
    logic       last_b;

    serial_sub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .bout(bout8)
    );

    serial_sub #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .d(d1), .bout(bout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full WIDTH=8 operation from IDLE, with a stray start mid-run.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv);
        logic [7:0] ed;
        logic       eb;
        ed = av - bv;
        eb = (av < bv);
        a8 = av; b8 = bv; start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("accept_busy", busy8, 1);
        chk("accept_done", done8, 0);
        for (int i = 1; i < 8; i++) begin
            start8 = (i == 4);
            a8 = 8'($urandom); b8 = 8'($urandom);
            step();
            chk("run_busy", busy8, 1);
            chk("run_done", done8, 0);
            chk("hold_d", d8, last_d);
            chk("hold_bout", bout8, last_b);
        end
        start8 = 1'b0;
        step();
        chk("fin_done", done8, 1);
        chk("fin_busy", busy8, 0);
        chk("fin_d", d8, ed);
        chk("fin_bout", bout8, eb);
        last_d = ed; last_b = eb;
        step();
        chk("post_done", done8, 0);
        chk("post_busy", busy8, 0);
        chk("post_d", d8, ed);
    endtask

    initial begin
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic [7:0] ea, eb;
        logic [1:0] ex;

        rst8 = 1'b1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        rst1 = 1'b1; start1 = 1'b1; a1 = 1'b1; b1 = 1'b0;
        step();
        step();
        chk("rst_busy8", busy8, 0);
        chk("rst_done8", done8, 0);
        chk("rst_d8", d8, 0);
        chk("rst_bout8", bout8, 0);
        chk("rst_busy1", busy1, 0);
        chk("rst_d1", d1, 0);
        rst8 = 1'b0; start8 = 1'b0; rst1 = 1'b0; start1 = 1'b0;
        last_d = 8'h00; last_b = 1'b0;
        step();
        chk("idle_busy8", busy8, 0);

        run8(8'h5A, 8'h3C);
        run8(8'h00, 8'h01);
        run8(8'h80, 8'h80);
        run8(8'hFF, 8'h00);
        run8(8'h44, 8'h22);
        run8(8'h01, 8'h02);
        for (int k = 0; k < 8; k++) begin
            run8(8'($urandom), 8'($urandom));
        end

        // start held high: acceptances every 9 cycles, operands from accepting edge only
        for (int c = 0; c < 28; c++) begin
            start8 = (c < 20);
            if (c == 0) begin
                a8 = 8'h10; b8 = 8'h01;
            end else begin
                a8 = 8'($urandom); b8 = 8'($urandom);
            end
            if (c < 20 && (c % 9) == 0) begin
                qa.push_back(a8);
                qb.push_back(b8);
            end
            step();
            if ((c % 9) == 8) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("b2b_done", done8, 1);
                chk("b2b_d", d8, 8'(ea - eb));
                chk("b2b_bout", bout8, (ea < eb) ? 1 : 0);
                last_d = ea - eb; last_b = (ea < eb);
            end else begin
                chk("b2b_nodone", done8, 0);
            end
            chk("b2b_busy", busy8, (c < 27 && (c % 9) != 8) ? 1 : 0);
        end
        start8 = 1'b0;

        // reset in the middle of a run
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        chk("abort_busy", busy8, 0);
        chk("abort_done", done8, 0);
        chk("abort_d", d8, 0);
        chk("abort_bout", bout8, 0);
        last_d = 8'h00; last_b = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("abort_nodone", done8, 0);
        end
        run8(8'h09, 8'h0A);

        // WIDTH=1: half-subtractor truth table
        for (int k = 0; k < 4; k++) begin
            ex = 2'(k);
            a1 = ex[1]; b1 = ex[0]; start1 = 1'b1;
            step();
            start1 = 1'b0;
            chk("w1_busy", busy1, 1);
            chk("w1_early_done", done1, 0);
            step();
            chk("w1_done", done1, 1);
            chk("w1_d", d1, 32'((ex[1] - ex[0]) & 1));
            chk("w1_bout", bout1, (ex[1] < ex[0]) ? 1 : 0);
            step();
            chk("w1_post_done", done1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
